// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling controller that fetches one 8-word cache block
// from pipelined main memory. It issues one read per cycle and writes each
// returned word into the data array. After the 8th return it writes the tag.
// fsm_busy is held for the whole fill.
//
// Build option: define CACHE_FILL_CWF_EN for critical-word-first ordering.
// With it, the fill starts at the missed word and wraps around the block.
// Without it, the block is always fetched from word 0 to word 7.
module cache_fill_fsm #(
   parameter int WORDS_PER_BLOCK = 8,
   parameter int MEM_LAT         = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic [15:0] memory_data,
   input  logic        memory_data_valid,
   output logic        fsm_busy,
   output logic        memory_req,
   output logic [15:0] memory_address,
   output logic        write_data_array,
   output logic [2:0]  data_word_sel,
   output logic [15:0] fill_data,
   output logic        write_tag_array,
   output logic        fill_done
);

   // The offset arithmetic below is hard-wired to a 3-bit word index, and the
   // controller relies on returns arriving strictly after their requests.
   generate
      if (WORDS_PER_BLOCK != 8 || MEM_LAT < 1) begin : g_bad_params
         $error("cache_fill_fsm: WORDS_PER_BLOCK must be 8 and MEM_LAT at least 1");
      end
   endgenerate

   localparam logic [3:0] BLOCK_WORDS = 4'(WORDS_PER_BLOCK);
   localparam logic [3:0] LAST_WORD   = 4'(WORDS_PER_BLOCK - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_TAG  = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] base_reg, base_next;
   logic [3:0]  issue_cnt_reg, issue_cnt_next;
   logic [3:0]  ret_cnt_reg, ret_cnt_next;
   logic [2:0]  req_offset;
   logic [2:0]  ret_offset;

`ifdef CACHE_FILL_CWF_EN
   logic [2:0]  start_reg, start_next;
   logic        addr_lsb_unused;

   // The byte-select bit of the miss address never matters to a word fill.
   assign addr_lsb_unused = miss_address[0];

   // Both counters walk the block from the missed word, wrapping modulo 8.
   assign req_offset = start_reg + issue_cnt_reg[2:0];
   assign ret_offset = start_reg + ret_cnt_reg[2:0];

   // Hold the starting word offset for the duration of the fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_reg <= 3'd0;
      end else begin
         start_reg <= start_next;
      end
   end

   // Capture the missed word offset when a new fill is accepted.
   always_comb begin
      start_next = start_reg;
      if (state_reg == ST_IDLE && miss_detected) begin
         start_next = miss_address[3:1];
      end
   end
`else
   logic [3:0]  addr_low_unused;

   // Sequential order: the word offset within the block is not needed.
   assign addr_low_unused = miss_address[3:0];

   // Both counters map directly onto word offsets 0..7.
   assign req_offset = issue_cnt_reg[2:0];
   assign ret_offset = ret_cnt_reg[2:0];
`endif

   // State, block base and counters; reset abandons any fill in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         base_reg      <= 16'h0000;
         issue_cnt_reg <= 4'd0;
         ret_cnt_reg   <= 4'd0;
      end else begin
         state_reg     <= state_next;
         base_reg      <= base_next;
         issue_cnt_reg <= issue_cnt_next;
         ret_cnt_reg   <= ret_cnt_next;
      end
   end

   // Next-state and output decode. Requests come from registered counters.
   // Data writes follow the memory return in the same cycle.
   always_comb begin
      state_next       = state_reg;
      base_next        = base_reg;
      issue_cnt_next   = issue_cnt_reg;
      ret_cnt_next     = ret_cnt_reg;
      fsm_busy         = 1'b0;
      memory_req       = 1'b0;
      memory_address   = 16'h0000;
      write_data_array = 1'b0;
      data_word_sel    = 3'd0;
      fill_data        = 16'h0000;
      write_tag_array  = 1'b0;
      fill_done        = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (miss_detected) begin
               state_next     = ST_FILL;
               base_next      = {miss_address[15:4], 4'b0000};
               issue_cnt_next = 4'd0;
               ret_cnt_next   = 4'd0;
            end
         end

         ST_FILL: begin
            fsm_busy       = 1'b1;
            fill_data      = memory_data;
            memory_address = base_reg | {12'h000, req_offset, 1'b0};
            // Request side: one word per cycle until all 8 are issued.
            if (issue_cnt_reg < BLOCK_WORDS) begin
               memory_req     = 1'b1;
               issue_cnt_next = issue_cnt_reg + 4'd1;
            end
            // Return side: returns come back in issue order, so the return
            // count alone selects the destination word.
            if (memory_data_valid && (ret_cnt_reg < BLOCK_WORDS)) begin
               write_data_array = 1'b1;
               data_word_sel    = ret_offset;
               ret_cnt_next     = ret_cnt_reg + 4'd1;
               if (ret_cnt_reg == LAST_WORD) begin
                  state_next = ST_TAG;
               end
            end
         end

         ST_TAG: begin
            fsm_busy        = 1'b1;
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            state_next      = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between a cache (I or D) and the multi-cycle main memory. When the cache reports a miss, it fetches the 8-word (16-byte) block containing the missed address with pipelined memory reads. It writes each returned word into the cache data array, then writes the tag. While it is active, it holds `fsm_busy` so the pipeline stalls.

## Interface
Parameters:
- `WORDS_PER_BLOCK`, 8: words per cache block; fixed at 8 (3-bit word offset).
- `MEM_LAT`, 4: memory read latency in cycles. Used by the bench only; the FSM counts `memory_data_valid` pulses and never counts cycles.

Ports:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `miss_detected`  in  1  level from cache tag compare; sampled only in IDLE.
- `miss_address`  in  16  byte address of the missing access.
- `memory_data`  in  16  read data from memory.
- `memory_data_valid`  in  1  one pulse per issued request, in issue order, `MEM_LAT` cycles after the request.
- `fsm_busy`  out  1  high in FILL and TAG.
- `memory_req`  out  1  read request strobe, one word per cycle.
- `memory_address`  out  16  byte address of the current request.
- `write_data_array`  out  1  cache data-array write enable.
- `data_word_sel`  out  3  word offset within the block for the data write.
- `fill_data`  out  16  data to write; equals `memory_data`, combinational.
- `write_tag_array`  out  1  tag/valid write enable, one cycle.
- `fill_done`  out  1  one-cycle pulse, coincident with `write_tag_array`.

## Operation
- **States:** IDLE, FILL, TAG.
- **IDLE:**
  - All outputs are 0.
  - If `miss_detected` is high at a clock edge, latch `base = {miss_address[15:4], 4'b0}` and `start = miss_address[3:1]`, clear `issue_cnt` and `ret_cnt` (4 bits each), and go to FILL.
- **FILL, request side:**
  - `memory_req = (issue_cnt < 8)`.
  - `memory_address = base | (order(issue_cnt) << 1)`.
  - `issue_cnt` increments on each cycle with `memory_req` high and saturates at 8.
- **FILL, return side:** on each `memory_data_valid`:
  - Assert `write_data_array`.
  - Drive `data_word_sel = order(ret_cnt)`.
  - Increment `ret_cnt`.
  - When the 8th valid arrives (`ret_cnt == 7` while valid), go to TAG.
- **Overlap:** requests and returns overlap. Returns can arrive while requests are still issuing.
- **TAG:** one cycle with `write_tag_array = 1` and `fill_done = 1`, then go to IDLE.
- **Word order:** `order(k) = k`; see Configuration for the alternative. All offset arithmetic is 3-bit, modulo 8.
- **Ignored inputs:**
  - `miss_detected` is ignored in FILL and TAG.
  - `miss_detected` is resampled in IDLE. The cache re-evaluates the hit after the tag write.
  - `memory_data_valid` is ignored in IDLE and TAG, and after 8 returns. No writes result.
- **Stall:** the pipeline stall is `miss_detected | fsm_busy`, formed by the cache.

## Timing
- **Reset:**
  - Asynchronous reset forces IDLE, clears counters and latched base/start, and drives every output to 0 immediately.
  - Reset mid-fill abandons the fill. No tag is written, so the partially filled block stays invalid.
  - Memory shares `rst_n`, so no stale returns survive reset.
- **Cycle sequence** (miss seen at cycle 0, `MEM_LAT = 4`):
  - Cycles 1–8: `memory_req`.
  - Cycles 5–12: data writes.
  - Cycle 13: TAG.
  - Cycle 14: IDLE, where a new miss can be sampled.
  - `fsm_busy` is high in cycles 1–13.
- **Fill latency:** 9 + `MEM_LAT` cycles from the miss sample to `fill_done`.
- **Output timing:**
  - `fsm_busy`, `memory_req`, `memory_address` and `write_tag_array` are decoded from registered state and counters. They have no combinational path from `miss_detected`.
  - `write_data_array` and `fill_data` follow `memory_data_valid` and `memory_data` combinationally in the same cycle.

## Configuration
- **`CACHE_FILL_CWF_EN` defined** (critical word first): `order(k) = (start + k) mod 8`. The missed word is requested and written first, and the sequence wraps around the block.
- **Undefined:** `order(k) = k`; the block is always fetched from word 0 to word 7.
- **Unaffected by the macro:** ports, state machine, latency, and the tag write after all 8 words.

## Test plan
- **Reset:** hold `rst_n = 0` with `miss_detected = 1` → all outputs 0 and no `memory_req`. Release → the fill starts on the next edge.
- **Default order:** miss at 0x1236, `MEM_LAT = 4`.
  - Cycles 1–8: `memory_address` = 0x1230, 0x1232, …, 0x123E.
  - Cycles 5–12: `data_word_sel` = 0 through 7, with `fill_data` matching memory.
  - Cycle 13: `write_tag_array` and `fill_done`.
  - `fsm_busy` high in cycles 1–13 only.
- **CWF_EN:** miss at 0x123A.
  - Request addresses: 0x123A, 0x123C, 0x123E, 0x1230, 0x1232, 0x1234, 0x1236, 0x1238.
  - `data_word_sel` = 5, 6, 7, 0, 1, 2, 3, 4.
- **Spurious inputs:**
  - `memory_data_valid` pulsed in IDLE → no `write_data_array`.
  - `miss_detected` toggled during FILL → addresses unchanged, exactly 8 requests.
- **Reset mid-fill:** assert `rst_n = 0` at cycle 6 → outputs 0 at once and no `write_tag_array`. New miss at 0x0040 → full 8-word fill from 0x0040 with `fill_done` 13 cycles after the sample.
- **Back-to-back:** `miss_detected` held high continuously through two fills → the second fill is sampled in the IDLE cycle right after TAG, with a one-cycle `fsm_busy` gap.
